// File: rtl/fp_pkg.sv
// Shared FP32 constants, field layouts and op/state encodings for the FP datapath.
package fp_pkg;

    localparam int          FP_EXP_W    = 8;
    localparam int          FP_MAN_W    = 23;
    localparam int          FP_BIAS     = 127;
    localparam logic [7:0]  FP_INF_EXP  = 8'hFF;
    localparam logic [31:0] FP_NAN      = 32'h7FC0_0000;
    localparam int          FP_DIV_ITER = 26;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fp_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fp_div_state_t;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic exception;
        logic dbz;
    } fp_flags_t;

    // Exponent 0 covers subnormals too: they are flushed to zero.
    function automatic logic fp_is_zero(fp32_t x);
        return x.exp == '0;
    endfunction

    function automatic logic fp_is_inf(fp32_t x);
        return (x.exp == FP_INF_EXP) && (x.frac == '0);
    endfunction

    function automatic logic fp_is_nan(fp32_t x);
        return (x.exp == FP_INF_EXP) && (x.frac != '0);
    endfunction

endpackage

// File: rtl/fp_div_if.sv
// Operand/result bus of fp_div. The i_abort line exists only when FP_DIV_ABORT_EN is defined.
interface fp_div_if;
    logic        i_vld;
    logic [31:0] i_a;
    logic [31:0] i_b;
`ifdef FP_DIV_ABORT_EN
    logic        i_abort;
`endif
    logic        o_busy;
    logic [31:0] o_res;
    logic        o_res_vld;
    logic        o_overflow;
    logic        o_underflow;
    logic        o_exception;
    logic        o_dbz;

    modport master (
        output i_vld, i_a, i_b,
`ifdef FP_DIV_ABORT_EN
        output i_abort,
`endif
        input  o_busy, o_res, o_res_vld, o_overflow, o_underflow, o_exception, o_dbz
    );

    modport slave (
        input  i_vld, i_a, i_b,
`ifdef FP_DIV_ABORT_EN
        input  i_abort,
`endif
        output o_busy, o_res, o_res_vld, o_overflow, o_underflow, o_exception, o_dbz
    );
endinterface

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even and FP32 packing with overflow/underflow flush.
module fp_round_pack
    import fp_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [23:0]       man,
    input  logic              guard,
    input  logic              sticky,
    output logic [31:0]       res,
    output logic              overflow,
    output logic              underflow
);

    logic                    round_up;
    logic [24:0]             man_rnd;
    logic [FP_MAN_W-1:0]     frac;
    logic signed [9:0]       exp_adj;

    always_comb begin
        round_up = guard & (sticky | man[0]);
        man_rnd  = {1'b0, man} + 25'(round_up);
        // A carry out of the mantissa renormalises by one place.
        if (man_rnd[24]) begin
            frac    = man_rnd[23:1];
            exp_adj = exp_in + 10'sd1;
        end else begin
            frac    = man_rnd[22:0];
            exp_adj = exp_in;
        end

        overflow  = (exp_adj >= 10'sd255);
        underflow = (exp_adj <= 10'sd0);

        if (overflow) begin
            res = {sign, FP_INF_EXP, {FP_MAN_W{1'b0}}};
        end else if (underflow) begin
            res = {sign, 31'h0};
        end else begin
            res = {sign, exp_adj[7:0], frac};
        end
    end

endmodule

// File: rtl/fp_div.sv
// Iterative FP32 divider (radix-2 restoring, RNE, flush-to-zero) with valid/busy handshake.
// Optional abort input enabled by defining FP_DIV_ABORT_EN.
module fp_div
    import fp_pkg::*;
#(
    parameter int ITER = FP_DIV_ITER
) (
    input  logic     clk,
    input  logic     rst,
    fp_div_if.slave  bus
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [ITER-1:0] LO_MASK_HI = {ITER{1'b1}} >> 25;
    localparam logic [ITER-1:0] LO_MASK_LO = {ITER{1'b1}} >> 26;

    fp_div_state_t     state, state_nx;

    fp32_t             a, b;
    logic              sign_in;
    logic signed [9:0] exp_in;

    logic              spec_hit;
    logic [31:0]       spec_res;
    fp_flags_t         spec_flags;

    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [23:0]       mb_r;
    logic [24:0]       rem;
    logic [24:0]       trial;
    logic [ITER-1:0]   q;
    logic [CNT_W-1:0]  cnt;

    logic [23:0]       norm_man;
    logic              norm_guard;
    logic              norm_sticky;
    logic signed [9:0] norm_exp;
    logic [31:0]       rp_res;
    logic              rp_overflow;
    logic              rp_underflow;

    logic [31:0]       pend_res;
    fp_flags_t         pend_flags;
    logic [31:0]       res_r;
    fp_flags_t         flags_r;
    logic              res_vld_r;

    assign a       = bus.i_a;
    assign b       = bus.i_b;
    assign sign_in = a.sign ^ b.sign;
    assign exp_in  = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp}) + 10'(FP_BIAS);

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        spec_hit   = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (fp_is_nan(a) || fp_is_nan(b) || (fp_is_zero(a) && fp_is_zero(b)) ||
            (fp_is_inf(a) && fp_is_inf(b))) begin
            spec_res             = FP_NAN;
            spec_flags.exception = 1'b1;
        end else if (fp_is_inf(a)) begin
            spec_res = {sign_in, FP_INF_EXP, {FP_MAN_W{1'b0}}};
        end else if (fp_is_inf(b)) begin
            spec_res = {sign_in, 31'h0};
        end else if (fp_is_zero(b)) begin
            spec_res       = {sign_in, FP_INF_EXP, {FP_MAN_W{1'b0}}};
            spec_flags.dbz = 1'b1;
        end else if (fp_is_zero(a)) begin
            spec_res = {sign_in, 31'h0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for all clocked state.
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.i_vld) state_nx = spec_hit ? DONE : DIV;
            DIV:     if (cnt == '0) state_nx = NORM;
            NORM:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
`ifdef FP_DIV_ABORT_EN
        if (bus.i_abort && (state == DIV || state == NORM)) state_nx = IDLE;
`endif
    end

    assign trial = rem - {1'b0, mb_r};

    // The quotient lies in (0.5, 2): pick the window by its integer bit.
    always_comb begin
        if (q[ITER-1]) begin
            norm_man    = q[ITER-1 -: 24];
            norm_guard  = q[ITER-25];
            norm_sticky = (|(q & LO_MASK_HI)) | (|rem);
            norm_exp    = exp_r;
        end else begin
            norm_man    = q[ITER-2 -: 24];
            norm_guard  = q[ITER-26];
            norm_sticky = (|(q & LO_MASK_LO)) | (|rem);
            norm_exp    = exp_r - 10'sd1;
        end
    end

    fp_round_pack u_round_pack (
        .sign      (sign_r),
        .exp_in    (norm_exp),
        .man       (norm_man),
        .guard     (norm_guard),
        .sticky    (norm_sticky),
        .res       (rp_res),
        .overflow  (rp_overflow),
        .underflow (rp_underflow)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            sign_r     <= 1'b0;
            exp_r      <= '0;
            mb_r       <= '0;
            rem        <= '0;
            q          <= '0;
            cnt        <= '0;
            pend_res   <= '0;
            pend_flags <= '0;
            res_r      <= '0;
            flags_r    <= '0;
            res_vld_r  <= 1'b0;
        end else begin
            res_vld_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_vld) begin
                        sign_r     <= sign_in;
                        exp_r      <= exp_in;
                        mb_r       <= {1'b1, b.frac};
                        rem        <= {2'b01, a.frac};
                        q          <= '0;
                        cnt        <= CNT_W'(ITER - 1);
                        pend_res   <= spec_res;
                        pend_flags <= spec_flags;
                    end
                end
                DIV: begin
                    q   <= {q[ITER-2:0], ~trial[24]};
                    rem <= trial[24] ? {rem[23:0], 1'b0} : {trial[23:0], 1'b0};
                    cnt <= cnt - 1'b1;
                end
                NORM: begin
                    pend_res   <= rp_res;
                    pend_flags <= '{overflow: rp_overflow, underflow: rp_underflow,
                                    exception: 1'b0, dbz: 1'b0};
                end
                DONE: begin
                    res_r     <= pend_res;
                    flags_r   <= pend_flags;
                    res_vld_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy      = (state != IDLE);
    assign bus.o_res       = res_r;
    assign bus.o_res_vld   = res_vld_r;
    assign bus.o_overflow  = flags_r.overflow;
    assign bus.o_underflow = flags_r.underflow;
    assign bus.o_exception = flags_r.exception;
    assign bus.o_dbz       = flags_r.dbz;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: exact-division reference model plus a per-cycle compare process.
module tb_fp_div;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_div_if bus ();

    fp_div #(.ITER(26)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;   // {overflow, underflow, exception, dbz}
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] last_res = '0;
    logic [3:0]  last_fl = '0;

    vec_t vecs [0:12] = '{
        '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000},  // 6/2
        '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000},  // 1/3 rounds up
        '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000},  // 1/1
        '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0001},  // -1/0
        '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0010},  // 0/0
        '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000},  // overflow
        '{32'h00800000, 32'h4B000000, 32'h00000000, 4'b0100},  // underflow
        '{32'hC0F00000, 32'h40200000, 32'hC0400000, 4'b0000},  // -7.5/2.5
        '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0010},  // NaN operand
        '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000},  // inf/0 is not dbz
        '{32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000},  // 2/-inf
        '{32'h00000001, 32'hC0400000, 32'h80000000, 4'b0000},  // subnormal/-3
        '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0010}   // inf/inf
    };

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Exact quotient with remainder, rounded half-to-even by comparing 2r with the divisor.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic [3:0] fl,
                                    output bit special);
        int     ea = int'(a[30:23]);
        int     eb = int'(b[30:23]);
        logic   s = a[31] ^ b[31];
        bit     a_nan = (ea == 255) && (a[22:0] != 0);
        bit     b_nan = (eb == 255) && (b[22:0] != 0);
        bit     a_inf = (ea == 255) && (a[22:0] == 0);
        bit     b_inf = (eb == 255) && (b[22:0] == 0);
        bit     a_zero = (ea == 0);
        bit     b_zero = (eb == 0);
        longint ma, mb, n, qi, r;
        int     e;
        special = 1'b1;
        fl = 4'b0000;
        res = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res = 32'h7FC00000;
            fl  = 4'b0010;
        end else if (a_inf) begin
            res = {s, 8'hFF, 23'h0};
        end else if (b_inf) begin
            res = {s, 31'h0};
        end else if (b_zero) begin
            res = {s, 8'hFF, 23'h0};
            fl  = 4'b0001;
        end else if (a_zero) begin
            res = {s, 31'h0};
        end else begin
            special = 1'b0;
            ma = longint'({1'b1, a[22:0]});
            mb = longint'({1'b1, b[22:0]});
            e  = ea - eb + 127;
            if (ma >= mb) n = ma << 23;
            else begin
                n = ma << 24;
                e = e - 1;
            end
            qi = n / mb;
            r  = n % mb;
            if ((2 * r > mb) || ((2 * r == mb) && qi[0])) qi = qi + 1;
            if (qi == (longint'(1) << 24)) begin
                qi = longint'(1) << 23;
                e  = e + 1;
            end
            if (e >= 255) begin
                res = {s, 8'hFF, 23'h0};
                fl  = 4'b1000;
            end else if (e <= 0) begin
                res = {s, 31'h0};
                fl  = 4'b0100;
            end else begin
                res = {s, e[7:0], qi[22:0]};
            end
        end
    endfunction

    // Compare process: handshake, busy window, held result and flags every cycle.
    bit         exp_vld, exp_busy;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_vld  = (exp_q.size() > 0) && (cyc == exp_q[0].acc + exp_q[0].lat);
            exp_busy = (exp_q.size() > 0) && (cyc >= exp_q[0].acc) &&
                       (cyc < exp_q[0].acc + exp_q[0].lat);
            check("o_res_vld", 64'(bus.o_res_vld), 64'(exp_vld));
            check("o_busy", 64'(bus.o_busy), 64'(exp_busy));
            if (exp_vld) begin
                last_res = exp_q[0].res;
                last_fl  = exp_q[0].fl;
                void'(exp_q.pop_front());
            end else if ((exp_q.size() > 0) && (cyc > exp_q[0].acc + exp_q[0].lat)) begin
                void'(exp_q.pop_front());
            end
            check("o_res", 64'(bus.o_res), 64'(last_res));
            check("flags", 64'({bus.o_overflow, bus.o_underflow, bus.o_exception, bus.o_dbz}),
                  64'(last_fl));
        end
    end

    task automatic push_expect(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] lit_res, input logic [3:0] lit_fl,
                               input int acc, input string name);
        logic [31:0] mres;
        logic [3:0]  mfl;
        bit          sp;
        ref_div(a, b, mres, mfl, sp);
        check({name, " model"}, {28'h0, mfl, mres}, {28'h0, lit_fl, lit_res});
        exp_q.push_back('{res: mres, fl: mfl, acc: acc, lat: sp ? 1 : 28});
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] lit_res, input logic [3:0] lit_fl,
                            input string name);
        @(negedge clk);
        bus.i_a   = a;
        bus.i_b   = b;
        bus.i_vld = 1'b1;
        push_expect(a, b, lit_res, lit_fl, cyc + 1, name);
        @(negedge clk);
        bus.i_vld = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check({name, " drain"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        bus.i_vld = 1'b0;
        bus.i_a   = '0;
        bus.i_b   = '0;
`ifdef FP_DIV_ABORT_EN
        bus.i_abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset o_res", 64'(bus.o_res), 64'h0);
        check("reset o_busy", 64'(bus.o_busy), 64'h0);
        check("reset o_res_vld", 64'(bus.o_res_vld), 64'h0);
        rst    = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, $sformatf("vec%0d", i));
            wait_done($sformatf("vec%0d", i));
        end

        // i_vld held for 40 cycles: 6/2 taken, 1/3 taken the cycle after its result.
        @(negedge clk);
        bus.i_a   = 32'h40C00000;
        bus.i_b   = 32'h40000000;
        bus.i_vld = 1'b1;
        acc = cyc + 1;
        push_expect(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, acc, "b2b first");
        push_expect(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, acc + 29, "b2b second");
        @(negedge clk);
        bus.i_a = 32'h3F800000;
        bus.i_b = 32'h40400000;
        repeat (38) @(negedge clk);
        bus.i_vld = 1'b0;
        wait_done("b2b");

        // Reset on the 10th edge of a division.
        start_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "rst op");
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        last_res = '0;
        last_fl  = '0;
        check("mid rst o_res", 64'(bus.o_res), 64'h0);
        check("mid rst o_busy", 64'(bus.o_busy), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        start_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "post rst");
        wait_done("post rst");

`ifdef FP_DIV_ABORT_EN
        start_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, "abort op");
        repeat (9) @(negedge clk);
        bus.i_abort = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("abort o_busy", 64'(bus.o_busy), 64'h0);
        @(negedge clk);
        bus.i_abort = 1'b0;
        repeat (40) @(negedge clk);
        check("abort o_res kept", 64'(bus.o_res), 64'h40400000);
        bus.i_abort = 1'b1;
        start_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "abort idle");
        bus.i_abort = 1'b0;
        wait_done("abort idle");
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_div.md
# fp_div

Iterative IEEE-754 single-precision divider computing `i_a / i_b`. It is the inverse-operation companion to the FP32 add/sub/multiply datapath and occupies the `op` slot that block currently leaves unused. A radix-2 restoring divider runs under a small FSM with a valid/busy handshake. Results are round-to-nearest-even, and subnormal inputs and outputs are flushed to zero.

## Interface
- `ITER`, default 26: quotient bits generated, comprising 1 integer bit, 23 fraction bits, guard and round. Fixed for FP32; exposed only for bench sweeps.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous and active-low. Logic is reset when `rst`=0 at a `clk` edge.
- `i_vld`, in, 1: operands valid. Accepted only when `o_busy`=0.
- `i_a`, in, 32: dividend, FP32.
- `i_b`, in, 32: divisor, FP32.
- `o_busy`, out, 1: high from the accept edge until the edge on which `o_res_vld` is asserted.
- `o_res`, out, 32: quotient. Holds its value until the next result.
- `o_res_vld`, out, 1: one-cycle pulse when `o_res` is new.
- `o_overflow`, `o_underflow`, `o_exception`, `o_dbz`, out, 1 each: sticky per result and updated together with `o_res`. `o_exception` flags NaN results. `o_dbz` flags a finite nonzero value divided by zero.
- `i_abort`, in, 1: only present under `FP_DIV_ABORT_EN`.

## Operation
- States are IDLE, DIV, NORM and DONE.
- IDLE:
  - On `i_vld`, latch the sign (`a[31]^b[31]`), the mantissas `{1,frac}` and the 10-bit signed exponent `ea - eb + 127`.
  - A special case goes directly to DONE with a preset result. Otherwise, load `rem = ma` and `cnt = ITER-1` and go to DIV.
- Special cases, in priority order. Exponent 0 is treated as zero and the sign is always `a^b` except for NaN.
  - Either operand NaN, 0/0, or inf/inf gives `0x7FC00000` with `o_exception`.
  - inf/x gives signed inf.
  - x/inf gives signed zero.
  - x/0 gives signed inf with `o_dbz`.
  - 0/x gives signed zero.
- DIV runs one iteration per cycle:
  - Compute `trial = rem - mb` (25 bits).
  - If `trial` is nonnegative, shift in q bit 1 and set `rem = trial<<1`. Otherwise shift in 0 and set `rem = rem<<1`.
  - When `cnt` reaches 0, go to NORM.
- NORM:
  - Define `sticky = |rem`.
  - If `q[25]` is set, the mantissa is `q[24:2]`, guard is `q[1]`, and sticky is `q[0]|sticky`.
  - Otherwise, the mantissa is `q[23:1]`, guard is `q[0]`, and the exponent is reduced by 1.
  - Apply RNE: increment when `guard & (sticky | lsb)`. A mantissa carry increments the exponent.
  - If the exponent is ≥255, the result is signed inf with `o_overflow`. If the exponent is ≤0, the result is signed zero with `o_underflow`.
  - Go to DONE.
- DONE: register `o_res` and the flags, pulse `o_res_vld`, clear `o_busy`, and return to IDLE.
- `i_vld` while busy is ignored. The operands are not queued.
- `i_vld` in the cycle after DONE is accepted normally, so the back-to-back issue interval is latency+1.

## Timing
- Reset values: `o_res`=0, all flags 0, `o_busy`=0, `o_res_vld`=0, FSM in IDLE, `q`, `rem` and `cnt` zero.
- Normal latency is 28 cycles: the `o_res_vld` edge is 28 clocks after the accept edge, made up of 26 DIV, 1 NORM and 1 DONE.
- Special-case latency is 1 cycle (accept edge, then DONE edge).
- If `rst` goes low during any state, the next edge returns all state and outputs to reset values and no `o_res_vld` follows.
- `o_busy` is combinationally equal to (state != IDLE), and it is 0 in the cycle `o_res_vld` is high.

## Configuration
- `FP_DIV_ABORT_EN` defined:
  - Adds the `i_abort` input.
  - `i_abort`=1 in DIV or NORM returns the FSM to IDLE on the next edge with no `o_res_vld`. `o_res` and the flags are unchanged.
  - `i_abort` in IDLE or DONE has no effect.
- Undefined: no port, and every accepted operation completes.

## Structure
- The shared package `fp_pkg` holds:
  - `FP_NAN`=`0x7FC00000`, `FP_INF_EXP`=`8'hFF`, `FP_BIAS`=127, the width constants `FP_EXP_W`=8 and `FP_MAN_W`=23.
  - The `fp_div_state_t` enum.
  - The `op` encoding, extended with `2'b11`=DIV.
- Sub-module `fp_round_pack` is combinational. It takes sign, 10-bit exponent, 24-bit mantissa, guard and sticky and returns the FP32 word plus overflow/underflow, and is reusable by the adder.

## Test plan
- `0x40C00000 / 0x40000000` (6/2) gives `0x40400000`. `o_res_vld` arrives exactly 28 cycles after accept and all flags are 0.
- `0x3F800000 / 0x40400000` (1/3) gives `0x3EAAAAAB`, exercising the RNE round-up. `0x3F800000 / 0x3F800000` gives `0x3F800000`.
- `0xBF800000 / 0x00000000` gives `0xFF800000` with `o_dbz`=1 after 1 cycle. `0x00000000 / 0x00000000` gives `0x7FC00000` with `o_exception`=1.
- `0x7F000000 / 0x3E800000` gives `0x7F800000` with `o_overflow`=1. `0x00800000 / 0x4B000000` gives `0x00000000` with `o_underflow`=1.
- With `i_vld` held high for 40 cycles on 6/2 followed by 1/3, only 6/2 is accepted; its result appears at cycle 28 and the second accept happens at cycle 29.
- `rst`=0 at cycle 10 of a division: outputs are at reset values next edge, no `o_res_vld` follows, and a new 6/2 afterwards returns `0x40400000`. Under `FP_DIV_ABORT_EN`, `i_abort` at cycle 10 gives the same behaviour with `o_res` preserved.
